// File: rtl/viterbi_node_updater.sv
// Viterbi frame sequencer: updates every node score of a left-to-right HMM in place in a 1-cycle-latency BRAM.
// Latency: INIT N_NODES+1 cycles, frame 3*N_NODES+1 cycles; starts are accepted only in IDLE.
module viterbi_node_updater #(
  parameter int N_NODES    = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int SELF_COST  = 2,
  parameter int TRANS_COST = 4
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              init_start,
  input  logic              frame_start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] emis_addr,
  input  logic [DATA_W-1:0] emis_data,
  output logic [ADDR_W-1:0] addra,
  output logic              wea,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] best_score,
  output logic [ADDR_W-1:0] best_node,
  output logic [DATA_W-1:0] last_score
);

  localparam logic [DATA_W-1:0] INF     = '1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N_NODES - 1);
  localparam logic [DATA_W-1:0] SELF_C  = DATA_W'(SELF_COST);
  localparam logic [DATA_W-1:0] TRANS_C = DATA_W'(TRANS_COST);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RD, S_CAP, S_WR, S_FIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] score;
    logic [ADDR_W-1:0] node;
  } best_t;

  state_t            state;
  logic [ADDR_W-1:0] i;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] new_q;
  best_t             run;
  logic              frame_op;

  logic [DATA_W-1:0] stay_c;
  logic [DATA_W-1:0] move_c;
  logic [DATA_W-1:0] new_c;

  // INF is absorbing; any carry out of DATA_W clamps to INF.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (a == INF || b == INF || s[DATA_W])
      return INF;
    return s[DATA_W-1:0];
  endfunction

  assign stay_c = sat_add(douta, SELF_C);
  assign move_c = sat_add(prev, TRANS_C);
  assign new_c  = sat_add((move_c < stay_c) ? move_c : stay_c, emis_data);

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      i          <= '0;
      prev       <= INF;
      new_q      <= '0;
      run        <= '{score: INF, node: '0};
      frame_op   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      emis_addr  <= '0;
      best_score <= '0;
      best_node  <= '0;
      last_score <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (init_start) begin
            state    <= S_INIT;
            i        <= '0;
            frame_op <= 1'b0;
            busy     <= 1'b1;
            wea      <= 1'b1;
            addra    <= '0;
            dina     <= '0;
          end else if (frame_start) begin
            state     <= S_RD;
            i         <= '0;
            frame_op  <= 1'b1;
            prev      <= INF;
            run       <= '{score: INF, node: '0};
            busy      <= 1'b1;
            addra     <= '0;
            emis_addr <= '0;
          end
        end
        S_INIT: begin
          if (i == LAST) begin
            state <= S_FIN;
            wea   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            i     <= i + 1'b1;
            addra <= i + 1'b1;
            dina  <= INF;
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          // prev must hold the pre-update score of node i for node i+1's move path.
          new_q <= new_c;
          prev  <= douta;
          dina  <= new_c;
          wea   <= 1'b1;
          state <= S_WR;
        end
        S_WR: begin
          wea <= 1'b0;
          if (new_q < run.score)
            run <= '{score: new_q, node: i};
          if (i == LAST) begin
            last_score <= new_q;
            state      <= S_FIN;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            i         <= i + 1'b1;
            addra     <= i + 1'b1;
            emis_addr <= i + 1'b1;
            state     <= S_RD;
          end
        end
        S_FIN: begin
          if (frame_op) begin
            best_score <= run.score;
            best_node  <= run.node;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/viterbi_node_updater.md
Name: viterbi_node_updater

Overview:
- Per-frame Viterbi recursion sequencer for the left-to-right word HMM.
- Drives the single-port node-score BRAM (64 x 16, one-cycle read latency, write-enable width 1) that sits directly downstream of it.
- On each new frame it updates every node score in place using fixed self/forward transition costs and per-node emission costs, then reports the best node.
- It also initialises the score memory before the first frame.

Parameters:
- N_NODES, 64: number of HMM nodes; must be at most 2**ADDR_W.
- ADDR_W, 6: BRAM address width.
- DATA_W, 16: score width. Unsigned cost; lower is better; all-ones = INF.
- SELF_COST, 2: cost of the self-loop transition.
- TRANS_COST, 4: cost of the transition from node i-1 to node i.

Ports:
- clka in 1: system clock, rising edge.
- rst in 1: asynchronous reset, active-high.
- init_start in 1: pulse; start memory initialisation.
- frame_start in 1: pulse; start one frame update.
- busy out 1: high while INIT or frame update is in progress.
- done out 1: one-cycle pulse when INIT or frame update completes.
- emis_addr out ADDR_W: node index for the external emission-cost memory.
- emis_data in DATA_W: emission cost; valid one cycle after emis_addr.
- addra out ADDR_W: BRAM address.
- wea out 1: BRAM write enable.
- dina out DATA_W: BRAM write data.
- douta in DATA_W: BRAM read data; valid one cycle after addra is sampled with wea=0.
- best_score out DATA_W: minimum new score of the last frame.
- best_node out ADDR_W: index of best_score.
- last_score out DATA_W: new score of node N_NODES-1 from the last frame.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal prev register = INF.
- Reset mid-operation aborts immediately with wea=0. BRAM contents are then undefined and the controller must issue INIT again.
- FSM states: IDLE, INIT, RD, CAP, WR, FIN.
- IDLE:
  - init_start goes to INIT with i=0.
  - else frame_start goes to RD with i=0, prev=INF, running best=INF/0.
  - If both are asserted in the same cycle, init wins.
  - Start pulses are ignored whenever busy=1.
- INIT:
  - One write per cycle: addra=i, wea=1, dina=0 for i=0, INF otherwise.
  - After i=N_NODES-1, go to FIN.
  - Duration: N_NODES cycles, then a done pulse.
- RD: addra=i, wea=0, emis_addr=i. Next state is CAP.
- CAP: douta and emis_data are valid.
  - stay = sat(douta + SELF_COST)
  - move = sat(prev + TRANS_COST)
  - new = sat(min(stay, move) + emis_data)
  - On a tie, select stay.
  - Register new; set prev <= douta (the old score, captured before it is overwritten). Next state is WR.
- WR: addra=i, wea=1, dina=new.
  - If new < running best (strict), update best and record index i. Ties keep the lower index.
  - If i==N_NODES-1, latch last_score=new and go to FIN; else i++ and go to RD.
- Saturating arithmetic:
  - Sums are computed at DATA_W+1 bits and clamped to all-ones.
  - An INF operand yields INF.
  - Node 0 uses prev=INF, so move=INF.
- Frame latency: 3*N_NODES cycles in RD/CAP/WR plus 1 cycle in FIN. done is asserted in FIN; busy falls in the same cycle.
- FIN: best_score and best_node are updated from the running values (frame only; INIT leaves them unchanged). Next state is IDLE.
- wea is high only in INIT and WR. addra and dina are held at their last values elsewhere.
- busy is high in INIT, RD, CAP and WR; low in IDLE and FIN.
- Index wrap: i never exceeds N_NODES-1. The counter resets to 0 on every start.

Test Plan:
- Reset/idle:
  - Assert rst mid-frame (i=10, state CAP).
  - Required: wea, busy and done drop to 0 asynchronously; all outputs are 0.
  - After release, a frame_start with no init is accepted and runs a full 3*64+1 cycles.
- Init:
  - Pulse init_start.
  - Required: exactly 64 consecutive wea=1 cycles; addr0 = 0, addr1..63 = 0xFFFF; done pulses once; busy is high for 64 cycles.
- Frame 1 after init, all emission costs = 1:
  - Node0 = 3, node1 = 5, nodes 2..63 = 0xFFFF (check via BRAM readback).
  - best_score = 3, best_node = 0, last_score = 0xFFFF.
  - done pulses 193 cycles after the start.
- Frame 2, emission costs = 1:
  - Node0 = 6; node1 = min(7, 7) + 1 = 8, with the tie taking the self path; node2 = 10.
  - best_score = 6, best_node = 0.
- Saturation:
  - Preload node5 = 0xFFF0 and node4 = 0xFFFF; set emission = 0x20.
  - Required: node5 new = 0xFFFF, with no wrap-around.
- Start collisions:
  - init_start and frame_start in the same cycle: only INIT runs.
  - frame_start pulsed while busy: ignored; exactly one done pulse.
